// File: rtl/jack_polj_small_pkg.sv
// Shared definitions for the polj small-polynomial mode-3 sequencer:
// datapath widths, default geometry, FSM encoding and the tail-lane mask helper.
package jack_polj_small_pkg;

    localparam int DW_13      = 13;
    localparam int DW_PH      = 16;
    localparam int NTRU_N_DEF = 509;
    localparam int LANES_DEF  = 8;
    localparam int MAX_LANES  = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Keep mask for the final beat: lanes at or beyond n mod lanes are padding.
    function automatic logic [MAX_LANES-1:0] tail_keep(input int n, input int lanes);
        int                   rem;
        logic [MAX_LANES-1:0] one;
        logic [MAX_LANES-1:0] mask;
        rem = n % lanes;
        one = {{(MAX_LANES-1){1'b0}}, 1'b1};
        if (rem != 0) begin
            mask = (one << rem) - one;
        end else begin
            mask = '1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/jack_polj_small_dly.sv
// Fixed-depth valid/data delay line; carries the write-side control bundle
// so it lines up with the ram1 read latency.
module jack_polj_small_dly
    import jack_polj_small_pkg::*;
#(
    parameter int             DEPTH    = 1,
    parameter int             W        = 8,
    parameter logic [W-1:0]   RST_DATA = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0] vld_r;
    logic [W-1:0]     dat_r [DEPTH];

    // Shift stages; stage 0 captures the input, the last stage drives the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_r[i] <= RST_DATA;
            end
        end else begin
            vld_r[0] <= in_valid;
            dat_r[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld_r[i] <= vld_r[i-1];
                dat_r[i] <= dat_r[i-1];
            end
        end
    end

    assign out_valid = vld_r[DEPTH-1];
    assign out_data  = dat_r[DEPTH-1];

endmodule

// File: rtl/jack_polj_small_ctrl3.sv
// Mode-3 small-polynomial sequencer: issues one ram1 read beat per cycle and
// replays the matching ram2 write controls RD_LAT cycles later.
module jack_polj_small_ctrl3
    import jack_polj_small_pkg::*;
#(
    parameter int NTRU_N = 509,
    parameter int LANES  = 8,
    parameter int RD_LAT = 1,
    parameter int AW     = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    src_base,
    input  logic [AW-1:0]    dst_base,
    output logic             busy,
    output logic             done,
    output logic             ram1_ena,
    output logic             ram1_enb,
    output logic [AW-1:0]    ram1_addra,
    output logic [AW-1:0]    ram1_addrb,
    output logic             ram2_wea,
    output logic             ram2_web,
    output logic [AW-1:0]    ram2_addra,
    output logic [AW-1:0]    ram2_addrb,
    output logic             f_ctr,
    output logic             carry_en,
    output logic [LANES-1:0] lane_keep
);

    localparam int               BEATS      = (NTRU_N + LANES - 1) / LANES;
    localparam int               BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0]    LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [1:0]       DRAIN_LAST = 2'(RD_LAT - 1);
    localparam logic [LANES-1:0] ONES       = {LANES{1'b1}};
    localparam logic [LANES-1:0] TAIL_KEEP  = LANES'(tail_keep(NTRU_N, LANES));
    localparam int               PW         = 1 + LANES + 2 * AW;
    localparam logic [PW-1:0]    RST_PAY    = {1'b1, ONES, {(2*AW){1'b0}}};

    state_t          state_r;
    state_t          state_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic            issue_nxt;
    logic            accept_s;

    logic            busy_r;
    logic            done_r;
    logic            ram1_en_r;
    logic [BW-1:0]   beat_r;
    logic [1:0]      drain_r;
    logic [AW-1:0]   rd_addra_r;
    logic [AW-1:0]   rd_addrb_r;
    logic [AW-1:0]   wr_addra_r;
    logic [AW-1:0]   wr_addrb_r;

    logic            first_s;
    logic            last_s;
    logic [LANES-1:0] keep_in_s;
    logic [PW-1:0]   pay_in_s;
    logic            wr_vld_s;
    logic [PW-1:0]   pay_out_s;

    assign accept_s = (state_r == ST_IDLE) && start;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ISSUE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (beat_r == LAST_BEAT) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (drain_r == DRAIN_LAST) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode, taken from the next state so the flops below line up with it.
    always_comb begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        issue_nxt = 1'b0;
        case (state_nxt)
            ST_IDLE:  busy_nxt = 1'b0;
            ST_ISSUE: begin
                busy_nxt  = 1'b1;
                issue_nxt = 1'b1;
            end
            ST_DRAIN: busy_nxt = 1'b1;
            ST_DONE: begin
                busy_nxt = 1'b1;
                done_nxt = 1'b1;
            end
            default: busy_nxt = 1'b0;
        endcase
    end

    // Status and read-side registers; bases are captured only on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ram1_en_r  <= 1'b0;
            beat_r     <= '0;
            drain_r    <= 2'd0;
            rd_addra_r <= '0;
            rd_addrb_r <= '0;
            wr_addra_r <= '0;
            wr_addrb_r <= '0;
        end else begin
            busy_r    <= busy_nxt;
            done_r    <= done_nxt;
            ram1_en_r <= issue_nxt;
            if (state_r == ST_DRAIN) begin
                drain_r <= drain_r + 2'd1;
            end else begin
                drain_r <= 2'd0;
            end
            if (accept_s) begin
                beat_r     <= '0;
                rd_addra_r <= src_base;
                rd_addrb_r <= src_base + AW'(1);
                wr_addra_r <= dst_base;
                wr_addrb_r <= dst_base + AW'(1);
            end else if (state_r == ST_ISSUE) begin
                beat_r     <= beat_r + BW'(1);
                rd_addra_r <= rd_addra_r + AW'(2);
                rd_addrb_r <= rd_addrb_r + AW'(2);
                wr_addra_r <= wr_addra_r + AW'(2);
                wr_addrb_r <= wr_addrb_r + AW'(2);
            end
        end
    end

    assign first_s = ram1_en_r && (beat_r == '0);
    assign last_s  = ram1_en_r && (beat_r == LAST_BEAT);

    // Write-side bundle in output form: {f_ctr, lane_keep, addra, addrb}.
    always_comb begin
        keep_in_s = ONES;
        if (last_s) begin
            keep_in_s = TAIL_KEEP;
        end else begin
            keep_in_s = ONES;
        end
        pay_in_s = {~first_s, keep_in_s, wr_addra_r, wr_addrb_r};
    end

    jack_polj_small_dly #(
        .DEPTH    (RD_LAT),
        .W        (PW),
        .RST_DATA (RST_PAY)
    ) u_dly (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (ram1_en_r),
        .in_data   (pay_in_s),
        .out_valid (wr_vld_s),
        .out_data  (pay_out_s)
    );

    assign busy       = busy_r;
    assign done       = done_r;
    assign ram1_ena   = ram1_en_r;
    assign ram1_enb   = ram1_en_r;
    assign ram1_addra = rd_addra_r;
    assign ram1_addrb = rd_addrb_r;
    assign ram2_wea   = wr_vld_s;
    assign ram2_web   = wr_vld_s;
    assign carry_en   = wr_vld_s;
    assign f_ctr      = pay_out_s[PW-1];
    assign lane_keep  = pay_out_s[PW-2 -: LANES];
    assign ram2_addra = pay_out_s[2*AW-1 -: AW];
    assign ram2_addrb = pay_out_s[AW-1:0];

endmodule

// File: tb/tb_jack_polj_small_ctrl3.sv
// Scoreboard bench: stimulus pushes expected reads/writes/done (with cycle stamps)
// into queues; negedge monitors pop and compare whenever the DUT presents them.
module tb_jack_polj_small_ctrl3;

    typedef struct {
        int         cyc;
        logic [6:0] a;
        logic [6:0] b;
        logic       f;
        logic [7:0] keep;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic       start0 = 1'b0;
    logic [6:0] src0 = 7'd0;
    logic [6:0] dst0 = 7'd0;
    logic       busy0, done0, r1ea0, r1eb0, r2wa0, r2wb0, fctr0, cen0;
    logic [6:0] r1aa0, r1ab0, r2aa0, r2ab0;
    logic [7:0] keep0;

    logic       start1 = 1'b0;
    logic       busy1, done1, r1ea1, r1eb1, r2wa1, r2wb1, fctr1, cen1;
    logic [6:0] r1aa1, r1ab1, r2aa1, r2ab1;
    logic [7:0] keep1;

    ev_t rq0[$];
    ev_t wq0[$];
    int  dq0[$];
    ev_t wq1[$];
    int  dq1[$];
    int  busy_lo0 = 1;
    int  busy_hi0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jack_polj_small_ctrl3 #(.NTRU_N(509), .LANES(8), .RD_LAT(1), .AW(7)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .src_base(src0), .dst_base(dst0),
        .busy(busy0), .done(done0), .ram1_ena(r1ea0), .ram1_enb(r1eb0),
        .ram1_addra(r1aa0), .ram1_addrb(r1ab0), .ram2_wea(r2wa0), .ram2_web(r2wb0),
        .ram2_addra(r2aa0), .ram2_addrb(r2ab0), .f_ctr(fctr0), .carry_en(cen0),
        .lane_keep(keep0)
    );

    jack_polj_small_ctrl3 #(.NTRU_N(512), .LANES(8), .RD_LAT(2), .AW(7)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .src_base(7'd0), .dst_base(7'h40),
        .busy(busy1), .done(done1), .ram1_ena(r1ea1), .ram1_enb(r1eb1),
        .ram1_addra(r1aa1), .ram1_addrb(r1ab1), .ram2_wea(r2wa1), .ram2_web(r2wb1),
        .ram2_addra(r2aa1), .ram2_addrb(r2ab1), .f_ctr(fctr1), .carry_en(cen1),
        .lane_keep(keep1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_busy"}, 32'(busy0), 32'd0);
        chk({tag, "_done"}, 32'(done0), 32'd0);
        chk({tag, "_r1en"}, 32'({r1ea0, r1eb0}), 32'd0);
        chk({tag, "_r1addr"}, 32'({r1aa0, r1ab0}), 32'd0);
        chk({tag, "_r2we"}, 32'({r2wa0, r2wb0}), 32'd0);
        chk({tag, "_r2addr"}, 32'({r2aa0, r2ab0}), 32'd0);
        chk({tag, "_fctr"}, 32'(fctr0), 32'd1);
        chk({tag, "_carry"}, 32'(cen0), 32'd0);
        chk({tag, "_keep"}, 32'(keep0), 32'hFF);
    endtask

    // Expected traffic for one 509-coefficient pass with RD_LAT=1, start accepted in cycle t.
    task automatic push_run0(input int t, input logic [6:0] src, input logic [6:0] dst);
        for (int k = 0; k < 64; k++) begin
            ev_t e;
            e.cyc  = t + 1 + k;
            e.a    = src + 7'(2 * k);
            e.b    = e.a + 7'd1;
            e.f    = 1'b1;
            e.keep = 8'hFF;
            rq0.push_back(e);
            e.cyc  = t + 2 + k;
            e.a    = dst + 7'(2 * k);
            e.b    = e.a + 7'd1;
            e.f    = (k != 0);
            e.keep = (k == 63) ? 8'h1F : 8'hFF;
            wq0.push_back(e);
        end
        dq0.push_back(t + 66);
        busy_lo0 = t + 1;
        busy_hi0 = t + 66;
    endtask

    // Expected writes for the 512-coefficient, RD_LAT=2 instance.
    task automatic push_run1(input int t);
        for (int k = 0; k < 64; k++) begin
            ev_t e;
            e.cyc  = t + 3 + k;
            e.a    = 7'h40 + 7'(2 * k);
            e.b    = e.a + 7'd1;
            e.f    = (k != 0);
            e.keep = 8'hFF;
            wq1.push_back(e);
        end
        dq1.push_back(t + 67);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rq0.size() == 0 && wq0.size() == 0 && dq0.size() == 0 &&
                wq1.size() == 0 && dq1.size() == 0 && !busy0 && !busy1) return;
        end
        chk({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    // Monitor for the default instance: reads, writes, done, busy window, idle values.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("u0_enb_eq_ena", 32'(r1eb0), 32'(r1ea0));
            chk("u0_busy", 32'(busy0), 32'(cyc >= busy_lo0 && cyc <= busy_hi0));
            if (r1ea0) begin
                if (rq0.size() == 0) chk("u0_unexpected_read", 32'd1, 32'd0);
                else begin
                    ev_t e;
                    e = rq0.pop_front();
                    chk("u0_rd_cyc", 32'(cyc), 32'(e.cyc));
                    chk("u0_rd_addra", 32'(r1aa0), 32'(e.a));
                    chk("u0_rd_addrb", 32'(r1ab0), 32'(e.b));
                end
            end
            if (r2wa0) begin
                chk("u0_web", 32'(r2wb0), 32'd1);
                chk("u0_carry", 32'(cen0), 32'd1);
                if (wq0.size() == 0) chk("u0_unexpected_write", 32'd1, 32'd0);
                else begin
                    ev_t e;
                    e = wq0.pop_front();
                    chk("u0_wr_cyc", 32'(cyc), 32'(e.cyc));
                    chk("u0_wr_addra", 32'(r2aa0), 32'(e.a));
                    chk("u0_wr_addrb", 32'(r2ab0), 32'(e.b));
                    chk("u0_wr_fctr", 32'(fctr0), 32'(e.f));
                    chk("u0_wr_keep", 32'(keep0), 32'(e.keep));
                end
            end else begin
                chk("u0_idle_web", 32'(r2wb0), 32'd0);
                chk("u0_idle_carry", 32'(cen0), 32'd0);
                chk("u0_idle_fctr", 32'(fctr0), 32'd1);
                chk("u0_idle_keep", 32'(keep0), 32'hFF);
            end
            if (done0) begin
                if (dq0.size() == 0) chk("u0_unexpected_done", 32'd1, 32'd0);
                else chk("u0_done_cyc", 32'(cyc), 32'(dq0.pop_front()));
            end
        end
    end

    // Monitor for the RD_LAT=2 / NTRU_N=512 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (r2wa1) begin
                if (wq1.size() == 0) chk("u1_unexpected_write", 32'd1, 32'd0);
                else begin
                    ev_t e;
                    e = wq1.pop_front();
                    chk("u1_wr_cyc", 32'(cyc), 32'(e.cyc));
                    chk("u1_wr_addra", 32'(r2aa1), 32'(e.a));
                    chk("u1_wr_addrb", 32'(r2ab1), 32'(e.b));
                    chk("u1_wr_fctr", 32'(fctr1), 32'(e.f));
                    chk("u1_wr_keep", 32'(keep1), 32'(e.keep));
                end
            end else begin
                chk("u1_idle_fctr", 32'(fctr1), 32'd1);
                chk("u1_idle_keep", 32'(keep1), 32'hFF);
            end
            if (done1) begin
                if (dq1.size() == 0) chk("u1_unexpected_done", 32'd1, 32'd0);
                else chk("u1_done_cyc", 32'(cyc), 32'(dq1.pop_front()));
            end
        end
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk_reset0("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Pass A: src 0, dst 0x40, with ignored starts mid-run and in the done cycle.
        t = cyc;
        src0 = 7'h00; dst0 = 7'h40; start0 = 1'b1;
        push_run0(t, 7'h00, 7'h40);
        @(negedge clk);
        start0 = 1'b0;
        wait_cyc(t + 10);
        src0 = 7'h11; dst0 = 7'h22; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_cyc(t + 66);
        src0 = 7'h33; dst0 = 7'h55; start0 = 1'b1;
        @(negedge clk);

        // Pass B back-to-back in the cycle after done, port-b wrap from 0x7F.
        t = cyc;
        src0 = 7'h7E; dst0 = 7'h10; start0 = 1'b1;
        push_run0(t, 7'h7E, 7'h10);
        @(negedge clk);
        start0 = 1'b0;
        wait_idle("passB");

        // Pass C aborted by reset at t+20; outputs must return to reset at once.
        t = cyc;
        src0 = 7'h05; dst0 = 7'h00; start0 = 1'b1;
        push_run0(t, 7'h05, 7'h00);
        @(negedge clk);
        start0 = 1'b0;
        wait_cyc(t + 20);
        rst_n = 1'b0;
        #1;
        chk_reset0("midrst");
        rq0.delete();
        wq0.delete();
        dq0.delete();
        busy_lo0 = 1;
        busy_hi0 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Pass D: clean full pass after reset release.
        t = cyc;
        src0 = 7'h05; dst0 = 7'h00; start0 = 1'b1;
        push_run0(t, 7'h05, 7'h00);
        @(negedge clk);
        start0 = 1'b0;
        wait_idle("passD");

        // RD_LAT=2, NTRU_N=512 instance.
        t = cyc;
        start1 = 1'b1;
        push_run1(t);
        @(negedge clk);
        start1 = 1'b0;
        wait_idle("u1pass");

        repeat (3) @(negedge clk);
        chk("end_rq0_empty", 32'(rq0.size()), 32'd0);
        chk("end_wq0_empty", 32'(wq0.size()), 32'd0);
        chk("end_dq0_empty", 32'(dq0.size()), 32'd0);
        chk("end_wq1_empty", 32'(wq1.size()), 32'd0);
        chk("end_dq1_empty", 32'(dq1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jack_polj_small_ctrl3.md
# jack_polj_small_ctrl3

Sequencer that streams one polynomial through the mode-3 small-polynomial datapath (g[i] = 3·(g[i−1] − g[i]), g[0] = −3·g[0]). Generates ram1 dual-port read addresses, the ram2 dual-port write addresses and enables, the first-beat select `f_ctr` and the carry-register enable. Aligns all write-side controls to the ram1 read latency, and masks padding lanes on the final beat. Sits between the polj instruction decoder (start/base addresses) and the mode-3 datapath/RAM pair.

## Interface
Parameters:
- `NTRU_N`, 509, polynomial length in coefficients
- `LANES`, 8, coefficients per beat (4 on port a + 4 on port b)
- `RD_LAT`, 1, ram1 read latency in cycles (1 or 2 supported)
- `AW`, 7, RAM address width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle request; honoured only in IDLE
- `src_base`  in  AW  ram1 word base address, latched on accepted start
- `dst_base`  in  AW  ram2 word base address, latched on accepted start
- `busy`  out  1  high from accepted start through the done cycle
- `done`  out  1  one-cycle pulse after the last write
- `ram1_ena` / `ram1_enb`  out  1  ram1 read enables
- `ram1_addra` / `ram1_addrb`  out  AW  ram1 read addresses
- `ram2_wea` / `ram2_web`  out  1  ram2 write enables
- `ram2_addra` / `ram2_addrb`  out  AW  ram2 write addresses
- `f_ctr`  out  1  0 = beat 0 (lane 0 uses −3·g[0]), 1 = all other beats
- `carry_en`  out  1  enable for the datapath carry register (lane-7 result of the current beat)
- `lane_keep`  out  LANES  per-lane write keep; zeroed lanes written as 0

## Operation
- BEATS = ceil(NTRU_N/LANES) (64 for defaults); beat k reads ram1 words src_base+2k (port a) and src_base+2k+1 (port b), writes ram2 words dst_base+2k / +2k+1.
- States: IDLE → ISSUE on accepted start; ISSUE issues one beat per cycle, k = 0..BEATS−1, → DRAIN after k = BEATS−1; DRAIN waits RD_LAT cycles for writes to complete → DONE; DONE asserts `done` for one cycle → IDLE.
- Write side is a RD_LAT-deep shift register of {valid, k==0, k==BEATS−1, addresses}; `ram2_we*`, `carry_en`, `f_ctr`, `lane_keep` are driven from its output stage.
- `f_ctr` = 0 exactly on the beat-0 write cycle; 1 on all other cycles, including idle.
- `lane_keep` = all ones except on the last-beat write cycle, where lanes ≥ NTRU_N mod LANES are 0; if NTRU_N mod LANES = 0, all ones.
- Address arithmetic wraps modulo 2^AW; no saturation.
- `start` while busy is ignored (no queuing, latched bases unchanged).

## Timing
- Reset values: `busy`, `done`, all enables, `carry_en` = 0; addresses = 0; `f_ctr` = 1; `lane_keep` = all ones; state IDLE.
- Start accepted in cycle T: beat k read issued at T+1+k; its write at T+1+k+RD_LAT; `done` at T+1+BEATS+RD_LAT; `busy` high T+1 through that cycle inclusive.
- Back-to-back: start accepted in the cycle after `done` (state IDLE); start in the `done` cycle is ignored.
- `rst_n` assertion mid-operation: all outputs return to reset values asynchronously; no partial `done`; in-flight writes dropped.

## Structure
- Shared package/header (jack_polj_small.vh): `DW_13`, `DW_PH`, NTRU_N, LANES, state encodings.
- One sub-module natural: `jack_polj_small_dly` — parameterised RD_LAT-deep valid/data delay line carrying the write-side control bundle.

## Test plan
- Defaults, src_base=0, dst_base=0x40, start at T → reads at T+1..T+64 (addra 0,2,…,126), writes at T+2..T+65 to 0x40.., `done` at T+66, exactly 64 write cycles.
- `f_ctr` checks: low only at T+2; with RD_LAT=2, low only at T+3 and `done` at T+67.
- Tail mask: NTRU_N=509 → last-beat `lane_keep`=8'b0001_1111; NTRU_N=512 → 8'hFF on every beat.
- Start pulsed at T+10 while busy and in the done cycle → ignored, no address/base change, single `done`.
- rst_n low at T+20 → all outputs at reset values same cycle; new start after release runs a full clean 64-beat pass.
- src_base=0x7E (AW=7) → port-b address wraps to 0x7F then 0x00, 0x01 …; no X on outputs.
